// File: rtl/servant_spi_flash.sv
// Read-only SPI NOR flash controller behind a Wishbone slave port.
// Each word read becomes one READ transaction: opcode, 24-bit address, four data bytes.
module servant_spi_flash #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_spi_sck,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK, GAP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] shreg;
  logic [31:0] rx;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic        div_done;
  logic        last_bit;
  logic        unused_ok;

  assign div_done  = (div_cnt == 8'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == 6'd63);
  assign unused_ok = ^{i_wb_dat, i_wb_sel, i_wb_adr[31:24], i_wb_adr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_wb_cyc) state_nxt = i_wb_we ? ACK : SHIFT;
      SHIFT:   if (!o_spi_cs_n && div_done && o_spi_sck && last_bit) state_nxt = ACK;
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cs_n still high while in SHIFT marks the first cycle of the transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg      <= '0;
      rx         <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      o_wb_rdt   <= '0;
      o_wb_ack   <= 1'b0;
      o_spi_sck  <= 1'b0;
      o_spi_cs_n <= 1'b1;
      o_spi_mosi <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc) begin
            if (i_wb_we) o_wb_ack <= 1'b1;
            else         shreg <= {READ_CMD, i_wb_adr[23:2], 2'b00, 32'h0};
          end
        end
        SHIFT: begin
          if (o_spi_cs_n) begin
            o_spi_cs_n <= 1'b0;
            o_spi_sck  <= 1'b0;
            o_spi_mosi <= shreg[63];
            div_cnt    <= '0;
            bit_cnt    <= '0;
          end else if (!div_done) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!o_spi_sck) begin
              o_spi_sck <= 1'b1;
              rx        <= {rx[30:0], i_spi_miso};
            end else begin
              o_spi_sck <= 1'b0;
              if (last_bit) begin
                o_spi_cs_n <= 1'b1;
                o_spi_mosi <= 1'b0;
                o_wb_ack   <= 1'b1;
                // flash sends the lowest-addressed byte first
                o_wb_rdt   <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
              end else begin
                bit_cnt    <= bit_cnt + 6'd1;
                shreg      <= {shreg[62:0], 1'b0};
                o_spi_mosi <= (bit_cnt >= 6'd31) ? 1'b0 : shreg[62];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/servant_spi_flash.md
Name: servant_spi_flash

Overview:
- Memory-mapped, read-only SPI NOR flash controller. Wishbone slave on the flash port of the CPU address decoder (region adr[31:29] = 3'b110).
- Turns each 32-bit Wishbone read into one SPI READ (0x03) transaction: command, 24-bit address, 4 data bytes.
- Returns the data word with a single-cycle ack. Writes are accepted and dropped.

Parameters:
- CLK_DIV, 2, i_clk cycles per SCK half-period; legal range 1..255.
- READ_CMD, 8'h03, SPI read opcode shifted out first.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_wb_adr  in  32  byte address; only [23:2] used
- i_wb_dat  in  32  write data (ignored)
- i_wb_sel  in  4  byte selects (ignored; always full-word read)
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  cycle/strobe request
- o_wb_rdt  out  32  read data, little-endian assembled
- o_wb_ack  out  1  one-cycle transfer acknowledge
- o_spi_sck  out  1  SPI clock, mode 0 (idle low)
- o_spi_cs_n  out  1  flash chip select, active low
- o_spi_mosi  out  1  serial data to flash
- i_spi_miso  in  1  serial data from flash

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst). Everything is registered on the rising edge of i_clk.
- Reset values (also forced mid-transfer):
  - o_spi_cs_n=1, o_spi_sck=0, o_spi_mosi=0
  - o_wb_ack=0, o_wb_rdt=0
  - state=IDLE, divider and bit counters=0
- A reset mid-transfer aborts it with no ack.
- States: IDLE -> SHIFT -> ACK -> GAP -> IDLE.
- IDLE:
  - i_wb_cyc=1 and i_wb_we=1: go to ACK. No SPI activity. o_wb_rdt unchanged.
  - i_wb_cyc=1 and i_wb_we=0: load the 64-bit shift register with {READ_CMD, i_wb_adr[23:2], 2'b00, 32'h0}, then go to SHIFT.
- Entering SHIFT (cycle after the request is sampled):
  - o_spi_cs_n=0, o_spi_sck=0, o_spi_mosi=bit 63 (the command MSB).
- SHIFT, per bit (64 bits, MSB first):
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - i_spi_miso is sampled on the i_clk edge that drives o_spi_sck 0->1.
  - MOSI advances to the next bit on the edge that drives SCK 1->0.
  - MOSI is held at 0 during the 32 data bits.
- Data assembly: data bytes arrive in flash order b0,b1,b2,b3. o_wb_rdt = {b3,b2,b1,b0}; each byte is received MSB first.
- End of the 64th bit's high phase: the same edge sets o_spi_sck=0, o_spi_cs_n=1, o_wb_rdt=assembled word, o_wb_ack=1 (state ACK).
- Read latency: ack is asserted exactly 1+128*CLK_DIV cycles after the edge that sampled the request (257 for CLK_DIV=2).
- Write latency: ack is asserted the cycle after sampling.
- ACK: o_wb_ack high for exactly one cycle. o_wb_rdt holds its value until the next completed read.
- GAP: one cycle that ignores i_wb_cyc. This absorbs the master's cyc drop and gives CS_n-high ≥ 2 cycles between transactions.
- Address handling:
  - i_wb_adr[1:0] are ignored; reads are always word-aligned.
  - i_wb_adr[31:24] are ignored.
- i_wb_cyc dropping during SHIFT does not abort; the transaction completes and acks.
- Request inputs are latched only in IDLE; changes later have no effect.

Test Plan:
- Reset: assert i_rst for 2 cycles, including once mid-SHIFT at bit 20 -> next cycle cs_n=1, sck=0, mosi=0, ack=0, rdt=0; no ack ever follows the aborted read.
- Read, CLK_DIV=2: adr=0xC0000104, flash model returns 0x11,0x22,0x33,0x44 ->
  - MOSI stream is 0x03,0x00,0x01,0x04.
  - rdt=0x44332211.
  - ack high for one cycle, 257 cycles after the request edge.
  - 64 SCK rising edges.
- Address masking: adr=0xDFFFFFFF -> SPI address 0xFFFFFC. adr=0xC0000107 -> SPI address 0x000104.
- Write: cyc=1, we=1, dat=0xDEADBEEF -> ack on the next cycle; cs_n stays 1 and sck stays 0 throughout; rdt unchanged.
- Back-to-back reads (master re-asserts cyc immediately after ack) -> cs_n high ≥ 2 cycles between transfers; both words correct.
- CLK_DIV=1: read of 0x000000 -> SCK toggles every cycle; ack at cycle 129; data correct.
